// File: rtl/arb_pkg.sv
// Shared widths and state encoding for the round-robin bank arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/decoder_2x4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module decoder_2x4 (
    input  logic [1:0] in,
    input  logic       en,
    output logic [3:0] out
);
    always_comb begin
        out = 4'b0000;
        if (en) out[in] = 1'b1;
    end
endmodule

// File: rtl/rr_bank_arbiter.sv
// Four-way round-robin arbiter: holds one grant until release, withdrawal
// or MAX_HOLD expiry, then rotates priority past the last grantee.
module rr_bank_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);
    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              grant_valid_q, grant_valid_d;
    logic              timeout_q, timeout_d;
    logic              hold_max;

    // Lowest rotated offset from ptr wins; iterating downward lets it overwrite last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] idx;
        rr_pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + ID_W'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign hold_max = (hold_cnt_q == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        hold_cnt_d    = hold_cnt_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d    = '0;
                grant_valid_d = 1'b0;
                if (req != '0) begin
                    grant_id_d    = rr_pick(req, ptr_q);
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HOLD_W'(1);
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (release_i || !req[grant_id_q] || hold_max) begin
                    // Release and withdrawal outrank the hold limit, so only a pure expiry pulses.
                    timeout_d     = !release_i && req[grant_id_q];
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    ptr_d         = grant_id_q + ID_W'(1);
                    state_d       = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

    decoder_2x4 u_grant_dec (
        .in  (grant_id_q),
        .en  (grant_valid_q),
        .out (grant)
    );
endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Random and directed stimulus for rr_bank_arbiter, checked every cycle against a behavioural model.
module tb_rr_bank_arbiter;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       release_i = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    // Model: who holds the resource, for how long, and where the search starts next.
    bit m_busy;
    int m_id, m_ptr, m_held;
    bit m_to;

    rr_bank_arbiter #(.MAX_HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .release_i(release_i),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_id = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                if (req != 4'b0000) begin
                    for (int k = 3; k >= 0; k--)
                        if (req[(m_ptr + k) % 4]) m_id = (m_ptr + k) % 4;
                    m_busy = 1;
                    m_held = 1;
                end
            end else if (release_i || !req[m_id] || m_held == H) begin
                m_to   = !release_i && req[m_id];
                m_busy = 0;
                m_ptr  = (m_id + 1) % 4;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        check("grant", int'(grant), m_busy ? (1 << m_id) : 0);
        check("grant_valid", int'(grant_valid), int'(m_busy));
        check("timeout", int'(timeout), int'(m_to));
        if (m_busy) check("grant_id", int'(grant_id), m_id);
    end

    task automatic step(input logic [3:0] r, input logic rel);
        req = r;
        release_i = rel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[4] = '{1, 2, 3, 0};
        // Reset held with every requester asking.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(grant_valid), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        check("first_id", int'(grant_id), 0);
        check("first_valid", int'(grant_valid), 1);

        // Rotation with one idle cycle between grants.
        foreach (exp_seq[i]) begin
            step(4'b1111, 1'b1);
            check("rot_bubble", int'(grant_valid), 0);
            step(4'b1111, 1'b0);
            check("rot_id", int'(grant_id), exp_seq[i]);
        end

        // Priority skip from ptr=1 over idle requesters 1 and 2.
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b0);
        check("skip_id", int'(grant_id), 3);
        check("skip_grant", int'(grant), 8);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b0);
        check("wrap_id", int'(grant_id), 0);

        // Withdrawal ends the grant without a timeout.
        step(4'b0000, 1'b0);
        check("wd_valid", int'(grant_valid), 0);
        check("wd_timeout", int'(timeout), 0);

        // Hold limit: exactly H cycles of grant, then a timeout pulse.
        step(4'b0100, 1'b0);
        check("to_grant0", int'(grant), 4);
        for (int i = 1; i < H; i++) begin
            step(4'b0100, 1'b0);
            check("to_grant", int'(grant), 4);
        end
        step(4'b0100, 1'b0);
        check("to_drop", int'(grant_valid), 0);
        check("to_pulse", int'(timeout), 1);
        step(4'b0100, 1'b0);
        check("to_clear", int'(timeout), 0);
        check("to_regrant", int'(grant_id), 2);

        // Release on the limit cycle suppresses the pulse.
        for (int i = 1; i < H; i++) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        check("relto_valid", int'(grant_valid), 0);
        check("relto_timeout", int'(timeout), 0);

        // Reset mid-grant of requester 2 clears the pointer.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        check("mid_id", int'(grant_id), 2);
        #2 rst_n = 1'b0;
        #1 check("async_grant", int'(grant), 0);
        check("async_valid", int'(grant_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111, 1'b0);
        check("post_rst_id", int'(grant_id), 0);

        // Release in IDLE is ignored.
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        check("idle_rel", int'(grant_valid), 0);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            if ($urandom_range(0, 400) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step(r, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_bank_arbiter.md
# rr_bank_arbiter

Round-robin arbiter sharing one datapath resource (a PE row, buffer bank or accumulator port) among four requesters in the mini TPU. It samples a 4-bit request vector, grants exactly one requester at a time, holds the grant until the requester releases, drops its request, or a hold limit expires, then rotates priority. The one-hot grant is produced by the existing `decoder_2x4` from the registered grant index, so the resource-select fabric is driven from a single 2-bit index.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input 4: per-requester request; bit k is requester k.
- `release_i` input 1: current grantee signals its transaction is complete; ignored when no grant is active.
- `grant` output 4: one-hot grant; all-zero when idle. Reset 4'b0000.
- `grant_id` output 2: index of the current grantee, valid only when `grant_valid`=1. Reset 2'b00.
- `grant_valid` output 1: a grant is active. Reset 0.
- `timeout` output 1: one-cycle pulse when a grant is ended by the `MAX_HOLD` limit. Reset 0.

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if `req`≠0, select a winner by searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4). Register `grant_id`=winner, `grant_valid`=1, `hold_cnt`=1, then go to GRANT. If `req`=0, stay in IDLE.
- GRANT: the grant ends at the first edge where any of these holds, in priority order:
  - `release_i`=1;
  - `req[grant_id]`=0 (requester withdrew);
  - `hold_cnt`==`MAX_HOLD`. Only this case sets `timeout`=1 for the next cycle.
- If none holds, increment `hold_cnt` and stay in GRANT.
- On grant end: `grant_valid`←0, `ptr`←`grant_id`+1 mod 4 (3 wraps to 0), next state IDLE.
- If release and timeout occur in the same cycle, release wins: no `timeout` pulse.
- `grant` = `decoder_2x4(in=grant_id, en=grant_valid)`. It is purely combinational from registers, so it is glitch-free relative to `clk`.
- Pointer register `ptr` (2 bits) resets to 0. It updates only on grant end, so fairness holds across bursts.
- `hold_cnt` width is 8 bits. It never exceeds `MAX_HOLD`, and it is cleared in IDLE.
- Requests from non-grantees during GRANT are ignored until the next IDLE arbitration.

## Timing
- Arbitration latency: `req` seen in IDLE at edge N produces `grant_valid`=1 in cycle N+1.
- Hold: the grant is visible for at least one full cycle.
- End latency: an end condition sampled at edge M produces `grant`=0 in cycle M+1.
- Bubble: the earliest next grant is cycle M+2, with one mandatory IDLE cycle between grants.
- Timeout bound: with `MAX_HOLD`=H and no release, the grant stays high exactly H cycles. `timeout` is high in the first cycle after the grant drops.
- Reset: `rst_n` low at any time, including mid-grant, immediately forces IDLE, `ptr`=0, `hold_cnt`=0 and all outputs to their reset values. No grant is issued in the first edge after `rst_n` rises unless `req`≠0 at that edge.
- `release_i` asserted while in IDLE has no effect.

## Structure
- Package `arb_pkg`:
  - `NUM_REQ`=4, `ID_W`=2, `HOLD_W`=8;
  - `typedef enum logic {IDLE, GRANT} arb_state_t`.
- Sub-module: one `decoder_2x4` instance for the grant vector.
- Winner selection is a small combinational rotate-priority function inside the block; it is not a separate module.
- Outputs `grant_id`, `grant_valid` and `timeout` come straight from flops.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=4'b1111 → `grant`=0, `grant_valid`=0, `timeout`=0. Release reset → first grant is requester 0 one cycle after the first sampling edge.
- **Rotation:** keep `req`=4'b1111 and pulse `release_i` one cycle after each grant → `grant_id` sequence 0,1,2,3,0 with one idle cycle between grants.
- **Priority skip:** `ptr`=1 (after granting 0), `req`=4'b1001 → grant 3, then `ptr`=0 and the next grant is 0.
- **Timeout:** `MAX_HOLD`=4, `req`=4'b0100, no release → `grant`=4'b0100 for exactly 4 cycles, then a one-cycle `timeout` pulse, an IDLE bubble, then requester 2 is re-granted.
- **Simultaneous release and timeout:** release on the cycle `hold_cnt`==`MAX_HOLD` → no `timeout` pulse. Also check withdrawal: `req[grant_id]`→0 mid-grant ends the grant next cycle.
- **Reset mid-grant:** assert `rst_n`=0 during GRANT of requester 2 → `grant` goes to 0 asynchronously and `ptr` returns to 0, so the next arbitration with `req`=4'b1111 grants 0.
